// File: rtl/synth_pkg.sv
// Shared definitions for the oscillator wave-shaping path: waveform
// encodings, phase/sample widths and the quarter-wave sine generator.
package synth_pkg;

  localparam int PHASE_W    = 11;
  localparam int SAMPLE_W   = 16;
  localparam int SAMPLE_MAX = 32767;
  localparam int ROM_AW     = 9;
  localparam int ROM_DW     = 15;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_e;

  // Quarter-wave entry i = round(SAMPLE_MAX*sin(pi/2*(i+0.5)/512)); half-step
  // offset keeps the table symmetric so no zero-crossing sample is repeated.
  function automatic int quarter_sine(input int idx);
    real x, term, acc;
    x    = (PI / 2.0) * ($itor(idx) + 0.5) / $itor(1 << ROM_AW);
    term = x;
    acc  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / $itor((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return $rtoi(acc * $itor(SAMPLE_MAX) + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// 512 x 15 quarter-wave sine table with registered read data.
// Contents are generated at elaboration from synth_pkg::quarter_sine.
module sine_quarter_rom
  import synth_pkg::*;
(
  input  logic              sCLK_XVXENVS,
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] data
);

  logic [ROM_DW-1:0] rom_tbl [2**ROM_AW];

  for (genvar g = 0; g < 2**ROM_AW; g++) begin : g_rom
    assign rom_tbl[g] = ROM_DW'(quarter_sine(g));
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    data <= rom_tbl[addr];
  end

endmodule

// File: rtl/osc_wave_shaper.sv
// Time-multiplexed phase-to-amplitude stage: turns one tagged oscillator
// phase per clock into a signed sample plus a per-slot phase-wrap flag.
module osc_wave_shaper
  import synth_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       reset_reg_N,
  input  logic                       in_valid,
  input  logic [V_WIDTH-1:0]         vx,
  input  logic [O_WIDTH-1:0]         ox,
  input  logic [PHASE_W-1:0]         phase_acc,
  input  logic [2*V_OSC-1:0]         wave_sel,
  input  logic [PHASE_W*V_OSC-1:0]   pulse_width,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       out_valid,
  output logic [V_WIDTH-1:0]         out_vx,
  output logic [O_WIDTH-1:0]         out_ox,
  output logic                       wrap_out
);

  localparam int SLOTS  = VOICES * V_OSC;
  localparam int SLOT_W = V_WIDTH + O_WIDTH;
  localparam int PAD_W  = SAMPLE_W - PHASE_W;

  function automatic logic signed [SAMPLE_W-1:0] saw_of(input logic [PHASE_W-1:0] ph);
    return {~ph[PHASE_W-1], ph[PHASE_W-2:0], {PAD_W{1'b0}}};
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] tri_of(input logic [PHASE_W-1:0] ph);
    logic [PHASE_W-2:0] t;
    t = ph[PHASE_W-1] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0];
    return {~t[PHASE_W-2], t[PHASE_W-3:0], {(PAD_W + 1){1'b0}}};
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] square_of(input logic [PHASE_W-1:0] ph,
                                                            input logic [PHASE_W-1:0] pw);
    return (ph < pw) ? SAMPLE_W'(SAMPLE_MAX) : SAMPLE_W'(-SAMPLE_MAX);
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] signed_sine(input logic sgn,
                                                              input logic [ROM_DW-1:0] mag);
    logic signed [SAMPLE_W-1:0] m;
    m = {1'b0, mag};
    return sgn ? -m : m;
  endfunction

  // S0: capture phase, tags and this oscillator's waveform controls
  logic                vld_p0;
  logic [PHASE_W-1:0]  phase_p0, pw_p0;
  logic [V_WIDTH-1:0]  vx_p0;
  logic [O_WIDTH-1:0]  ox_p0;
  wave_e               sel_p0;

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) vld_p0 <= 1'b0;
    else              vld_p0 <= in_valid;
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    phase_p0 <= phase_acc;
    vx_p0    <= vx;
    ox_p0    <= ox;
    sel_p0   <= wave_e'(wave_sel[2*int'(ox) +: 2]);
    pw_p0    <= pulse_width[PHASE_W*int'(ox) +: PHASE_W];
  end

  // S1: shape non-sine waves, form ROM address, detect wrap
  logic [SLOTS-1:0]           prev_msb;
  logic [SLOT_W-1:0]          slot_p0;
  logic                       wrap_s1;
  logic [ROM_AW-1:0]          q_s1;
  logic signed [SAMPLE_W-1:0] shaped_s1;

  assign slot_p0 = {vx_p0, ox_p0};
  assign wrap_s1 = vld_p0 & prev_msb[slot_p0] & ~phase_p0[PHASE_W-1];
  assign q_s1    = phase_p0[PHASE_W-2] ? ~phase_p0[ROM_AW-1:0] : phase_p0[ROM_AW-1:0];

  always_comb begin
    shaped_s1 = saw_of(phase_p0);
    case (sel_p0)
      WAVE_SQUARE: shaped_s1 = square_of(phase_p0, pw_p0);
      WAVE_TRI:    shaped_s1 = tri_of(phase_p0);
      default:     shaped_s1 = saw_of(phase_p0);
    endcase
  end

  // Written on the same edge the slot leaves S0, so an immediately following
  // access to the same slot already reads the updated bit.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N)  prev_msb          <= '0;
    else if (vld_p0)   prev_msb[slot_p0] <= phase_p0[PHASE_W-1];
  end

  logic                       vld_p1, sign_p1, wrap_p1;
  logic [ROM_AW-1:0]          q_p1;
  logic signed [SAMPLE_W-1:0] shaped_p1;
  wave_e                      sel_p1;
  logic [V_WIDTH-1:0]         vx_p1;
  logic [O_WIDTH-1:0]         ox_p1;

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) vld_p1 <= 1'b0;
    else              vld_p1 <= vld_p0;
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    q_p1      <= q_s1;
    sign_p1   <= phase_p0[PHASE_W-1];
    shaped_p1 <= shaped_s1;
    sel_p1    <= sel_p0;
    wrap_p1   <= wrap_s1;
    vx_p1     <= vx_p0;
    ox_p1     <= ox_p0;
  end

  // S2: ROM read lands alongside the rest of the slot
  logic [ROM_DW-1:0]          rom_p2;
  logic                       vld_p2, sign_p2, wrap_p2;
  logic signed [SAMPLE_W-1:0] shaped_p2;
  wave_e                      sel_p2;
  logic [V_WIDTH-1:0]         vx_p2;
  logic [O_WIDTH-1:0]         ox_p2;

  sine_quarter_rom u_rom (
    .sCLK_XVXENVS (sCLK_XVXENVS),
    .addr         (q_p1),
    .data         (rom_p2)
  );

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) vld_p2 <= 1'b0;
    else              vld_p2 <= vld_p1;
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    sign_p2   <= sign_p1;
    shaped_p2 <= shaped_p1;
    sel_p2    <= sel_p1;
    wrap_p2   <= wrap_p1;
    vx_p2     <= vx_p1;
    ox_p2     <= ox_p1;
  end

  // Output: sign the sine, select the waveform, hold on idle cycles
  logic signed [SAMPLE_W-1:0] final_s2;

  assign final_s2 = (sel_p2 == WAVE_SINE) ? signed_sine(sign_p2, rom_p2) : shaped_p2;

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      out_valid  <= 1'b0;
      sample_out <= '0;
      out_vx     <= '0;
      out_ox     <= '0;
      wrap_out   <= 1'b0;
    end else begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        sample_out <= final_s2;
        out_vx     <= vx_p2;
        out_ox     <= ox_p2;
        wrap_out   <= wrap_p2;
      end
    end
  end

endmodule

// File: tb/tb_osc_wave_shaper.sv
// Directed bench for osc_wave_shaper: waveforms, latency, tags, wrap
// detection and reset behaviour against hand-computed values.
module tb_osc_wave_shaper;

  logic               sCLK_XVXENVS = 1'b0;
  logic               reset_reg_N;
  logic               in_valid;
  logic [2:0]         vx;
  logic [1:0]         ox;
  logic [10:0]        phase_acc;
  logic [7:0]         wave_sel;
  logic [43:0]        pulse_width;
  logic signed [15:0] sample_out;
  logic               out_valid;
  logic [2:0]         out_vx;
  logic [1:0]         out_ox;
  logic               wrap_out;

  int checks   = 0;
  int failures = 0;

  int                 q_vx[$], q_ox[$], q_ph[$];
  logic signed [15:0] r_smp[$];
  logic               r_wrap[$];
  logic [2:0]         r_vx[$];
  logic [1:0]         r_ox[$];
  int                 r_cyc[$];

  osc_wave_shaper dut (
    .sCLK_XVXENVS (sCLK_XVXENVS),
    .reset_reg_N  (reset_reg_N),
    .in_valid     (in_valid),
    .vx           (vx),
    .ox           (ox),
    .phase_acc    (phase_acc),
    .wave_sel     (wave_sel),
    .pulse_width  (pulse_width),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .out_vx       (out_vx),
    .out_ox       (out_ox),
    .wrap_out     (wrap_out)
  );

  always #5 sCLK_XVXENVS = ~sCLK_XVXENVS;

  task automatic push(input int v, input int o, input int p);
    q_vx.push_back(v);
    q_ox.push_back(o);
    q_ph.push_back(p);
  endtask

  // Drives queued slots on consecutive cycles and records every valid output
  // together with the cycle it appeared (input k is captured at cycle k).
  task automatic run_seq();
    int n;
    n = q_ph.size();
    r_smp.delete(); r_wrap.delete(); r_vx.delete(); r_ox.delete(); r_cyc.delete();
    for (int c = 0; c < n + 6; c++) begin
      @(negedge sCLK_XVXENVS);
      if (c < n) begin
        in_valid  = 1'b1;
        vx        = 3'(q_vx[c]);
        ox        = 2'(q_ox[c]);
        phase_acc = 11'(q_ph[c]);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge sCLK_XVXENVS);
      #1;
      if (out_valid) begin
        r_smp.push_back(sample_out);
        r_wrap.push_back(wrap_out);
        r_vx.push_back(out_vx);
        r_ox.push_back(out_ox);
        r_cyc.push_back(c);
      end
    end
    q_vx.delete(); q_ox.delete(); q_ph.delete();
  endtask

  task automatic test_reset();
    reset_reg_N = 1'b0;
    in_valid    = 1'b0;
    vx          = '0;
    ox          = '0;
    phase_acc   = '0;
    wave_sel    = '0;
    pulse_width = '0;
    repeat (2) @(posedge sCLK_XVXENVS);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (sample_out !== 16'sd0 || wrap_out !== 1'b0) begin
      failures++; $display("FAIL reset_data got sample=%0d wrap=%b exp 0/0", sample_out, wrap_out);
    end
    checks++;
    if (out_vx !== 3'd0 || out_ox !== 2'd0) begin
      failures++; $display("FAIL reset_tags got=(%0d,%0d) exp=(0,0)", out_vx, out_ox);
    end
    @(negedge sCLK_XVXENVS);
    reset_reg_N = 1'b1;
  endtask

  task automatic test_saw();
    int exp_s[3] = '{-32768, 0, 32736};
    logic signed [15:0] s;
    wave_sel = 8'b01_01_01_01;
    push(0, 0, 0); push(0, 0, 1024); push(0, 0, 2047);
    run_seq();
    checks++;
    if (r_smp.size() != 3) begin
      failures++; $display("FAIL saw_count got=%0d exp=3", r_smp.size());
    end
    for (int i = 0; i < 3; i++) begin
      s = (i < r_smp.size()) ? r_smp[i] : 16'hxxxx;
      checks++;
      if (s !== 16'(exp_s[i])) begin
        failures++; $display("FAIL saw[%0d] sample got=%0d exp=%0d", i, s, exp_s[i]);
      end
      checks++;
      if (i >= r_cyc.size() || r_cyc[i] != i + 3) begin
        failures++; $display("FAIL saw[%0d] latency got_cycle=%0d exp=%0d", i,
                             (i < r_cyc.size()) ? r_cyc[i] : -1, i + 3);
      end
      checks++;
      if (i >= r_vx.size() || r_vx[i] !== 3'd0 || r_ox[i] !== 2'd0) begin
        failures++; $display("FAIL saw[%0d] tags wrong exp=(0,0)", i);
      end
    end
  endtask

  task automatic test_square();
    int exp_s[5] = '{32767, -32767, -32767, 32767, -32767};
    int exp_o[5] = '{0, 0, 1, 2, 2};
    logic signed [15:0] s;
    wave_sel    = 8'b10_10_10_10;
    pulse_width = {11'd0, 11'd2047, 11'd0, 11'd1024};
    push(0, 0, 1023); push(0, 0, 1024); push(0, 1, 0); push(0, 2, 2046); push(0, 2, 2047);
    run_seq();
    for (int i = 0; i < 5; i++) begin
      s = (i < r_smp.size()) ? r_smp[i] : 16'hxxxx;
      checks++;
      if (s !== 16'(exp_s[i])) begin
        failures++; $display("FAIL square[%0d] sample got=%0d exp=%0d", i, s, exp_s[i]);
      end
      checks++;
      if (i >= r_ox.size() || r_ox[i] !== 2'(exp_o[i])) begin
        failures++; $display("FAIL square[%0d] out_ox got=%0d exp=%0d", i,
                             (i < r_ox.size()) ? int'(r_ox[i]) : -1, exp_o[i]);
      end
    end
  endtask

  task automatic test_sine();
    int exp_s[4] = '{50, 32767, -50, -32767};
    logic signed [15:0] s;
    wave_sel = 8'b00_00_00_00;
    push(0, 0, 0); push(0, 0, 512); push(0, 0, 1024); push(0, 0, 1536);
    run_seq();
    for (int i = 0; i < 4; i++) begin
      s = (i < r_smp.size()) ? r_smp[i] : 16'hxxxx;
      checks++;
      if (s !== 16'(exp_s[i])) begin
        failures++; $display("FAIL sine[%0d] sample got=%0d exp=%0d", i, s, exp_s[i]);
      end
    end
  endtask

  task automatic test_triangle();
    int exp_s[4] = '{-32768, 32704, 32704, -32768};
    logic signed [15:0] s;
    wave_sel = 8'b11_11_11_11;
    push(0, 0, 0); push(0, 0, 1023); push(0, 0, 1024); push(0, 0, 2047);
    run_seq();
    for (int i = 0; i < 4; i++) begin
      s = (i < r_smp.size()) ? r_smp[i] : 16'hxxxx;
      checks++;
      if (s !== 16'(exp_s[i])) begin
        failures++; $display("FAIL tri[%0d] sample got=%0d exp=%0d", i, s, exp_s[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_s[4] = '{32767, -32768, 32767, 32704};
    logic signed [15:0] s;
    wave_sel    = 8'b11_10_01_00;
    pulse_width = {11'd0, 11'd2047, 11'd0, 11'd1024};
    push(1, 0, 512); push(1, 1, 0); push(1, 2, 5); push(1, 3, 1023);
    run_seq();
    for (int i = 0; i < 4; i++) begin
      s = (i < r_smp.size()) ? r_smp[i] : 16'hxxxx;
      checks++;
      if (s !== 16'(exp_s[i])) begin
        failures++; $display("FAIL b2b[%0d] sample got=%0d exp=%0d", i, s, exp_s[i]);
      end
      checks++;
      if (i >= r_ox.size() || r_vx[i] !== 3'd1 || r_ox[i] !== 2'(i) || r_cyc[i] != i + 3) begin
        failures++; $display("FAIL b2b[%0d] tags/latency wrong exp=(1,%0d)@%0d", i, i, i + 3);
      end
    end
  endtask

  task automatic test_wrap();
    logic exp_w[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int   exp_v[5] = '{2, 5, 2, 2, 2};
    logic w;
    wave_sel = 8'b01_01_01_01;
    push(2, 1, 2000); push(5, 3, 100); push(2, 1, 48); push(2, 1, 2040); push(2, 1, 8);
    run_seq();
    for (int i = 0; i < 5; i++) begin
      w = (i < r_wrap.size()) ? r_wrap[i] : 1'bx;
      checks++;
      if (w !== exp_w[i]) begin
        failures++; $display("FAIL wrap[%0d] wrap_out got=%b exp=%b", i, w, exp_w[i]);
      end
      checks++;
      if (i >= r_vx.size() || r_vx[i] !== 3'(exp_v[i])) begin
        failures++; $display("FAIL wrap[%0d] out_vx got=%0d exp=%0d", i,
                             (i < r_vx.size()) ? int'(r_vx[i]) : -1, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    wave_sel = 8'b00_00_00_00;
    for (int k = 0; k < 4; k++) begin
      @(negedge sCLK_XVXENVS);
      in_valid  = 1'b1;
      vx        = 3'd3;
      ox        = 2'd0;
      phase_acc = 11'(1500 + 100 * k);
    end
    @(posedge sCLK_XVXENVS);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre out_valid got=%b exp=1", out_valid);
    end
    @(negedge sCLK_XVXENVS);
    in_valid = 1'b0;
    #1 reset_reg_N = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sample_out !== 16'sd0 || wrap_out !== 1'b0 ||
        out_vx !== 3'd0 || out_ox !== 2'd0) begin
      failures++; $display("FAIL rst_mid_async got valid=%b sample=%0d wrap=%b tags=(%0d,%0d) exp all 0",
                           out_valid, sample_out, wrap_out, out_vx, out_ox);
    end
    repeat (2) @(posedge sCLK_XVXENVS);
    @(negedge sCLK_XVXENVS);
    reset_reg_N = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge sCLK_XVXENVS);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL rst_mid_flush[%0d] out_valid got=%b exp=0", j, out_valid);
      end
    end
    @(negedge sCLK_XVXENVS);
    in_valid  = 1'b1;
    vx        = 3'd3;
    ox        = 2'd0;
    phase_acc = 11'd0;
    @(posedge sCLK_XVXENVS);
    @(negedge sCLK_XVXENVS);
    in_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      if (j > 1) @(posedge sCLK_XVXENVS);
      #1;
      if (j == 1) begin
        @(posedge sCLK_XVXENVS);
        #1;
      end
      checks++;
      if (out_valid !== (j == 3)) begin
        failures++; $display("FAIL rst_mid_first[%0d] out_valid got=%b exp=%b", j, out_valid, j == 3);
      end
    end
    checks++;
    if (sample_out !== 16'sd50 || wrap_out !== 1'b0 || out_vx !== 3'd3 || out_ox !== 2'd0) begin
      failures++; $display("FAIL rst_mid_sample got sample=%0d wrap=%b tags=(%0d,%0d) exp 50/0/(3,0)",
                           sample_out, wrap_out, out_vx, out_ox);
    end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_square();
    test_sine();
    test_triangle();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
